present_key_sched_seq: RTL and testbench

Sequential PRESENT round-key generator. It accepts a master key (80- or 128-bit) and iterates the PRESENT key-update function one round per accepted output. It streams the 32 round keys K1..K32, each 64 bits, over a valid/ready handshake to the downstream cipher round datapath. It sits between the key-load interface and the encryption round engine, and holds the evolving key register so the round engine never sees a partially updated key.

---
 rtl/present_key_sched_seq_if.sv | 26 ++
 rtl/present_key_sched_seq.sv | 121 ++++++++++++
 tb/tb_present_key_sched_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/present_key_sched_seq_if.sv
// Handshake bundle between the key loader, the PRESENT round-key generator
// and the round engine that consumes the keys.
interface present_key_sched_seq_if #(
  parameter bit KEY_128 = 1'b0
);
  localparam int KEY_W = KEY_128 ? 128 : 80;

  logic [KEY_W-1:0] key_in;
  logic             key_valid;
  logic             key_ready;
  logic [63:0]      rk_out;
  logic [4:0]       rk_idx;
  logic             rk_valid;
  logic             rk_ready;
  logic             rk_last;

  modport master (
    output key_in, key_valid, rk_ready,
    input  key_ready, rk_out, rk_idx, rk_valid, rk_last
  );

  modport slave (
    input  key_in, key_valid, rk_ready,
    output key_ready, rk_out, rk_idx, rk_valid, rk_last
  );
endinterface

// File: rtl/present_key_sched_seq.sv
// Sequential PRESENT key schedule: loads an 80/128-bit master key and streams
// round keys K1..K32, advancing the key register only on an accepted output.
module present_sbox (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb begin
    case (din)
      4'h0: dout = 4'hC;
      4'h1: dout = 4'h5;
      4'h2: dout = 4'h6;
      4'h3: dout = 4'hB;
      4'h4: dout = 4'h9;
      4'h5: dout = 4'h0;
      4'h6: dout = 4'hA;
      4'h7: dout = 4'hD;
      4'h8: dout = 4'h3;
      4'h9: dout = 4'hE;
      4'hA: dout = 4'hF;
      4'hB: dout = 4'h8;
      4'hC: dout = 4'h4;
      4'hD: dout = 4'h7;
      4'hE: dout = 4'h1;
      default: dout = 4'h2;
    endcase
  end
endmodule

module present_key_sched_seq #(
  parameter bit KEY_128 = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  present_key_sched_seq_if.slave  bus
);
  localparam int KEY_W = KEY_128 ? 128 : 80;
  localparam int NSBOX = KEY_128 ? 2 : 1;
  // Bit position where the round counter is folded into the rotated key.
  localparam int CPOS  = KEY_128 ? 62 : 15;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [KEY_W-1:0] key_reg, key_next;
  logic [4:0]       idx_reg, idx_next;
  logic             key_ready;
  logic             rk_valid;

  logic [KEY_W-1:0]   rot;
  logic [KEY_W-1:0]   upd;
  logic [4*NSBOX-1:0] sbox_out;
  logic [4:0]         cnt;

  assign cnt = idx_reg + 5'd1;
  assign rot = {key_reg[KEY_W-62:0], key_reg[KEY_W-1:KEY_W-61]};

  genvar gi;
  generate
    for (gi = 0; gi < NSBOX; gi++) begin : g_sbox
      present_sbox u_sbox (
        .din  (rot[KEY_W-1-4*gi -: 4]),
        .dout (sbox_out[4*NSBOX-1-4*gi -: 4])
      );
    end
  endgenerate

  always_comb begin
    upd = rot;
    upd[KEY_W-1 -: 4*NSBOX] = sbox_out;
    upd[CPOS +: 5] = rot[CPOS +: 5] ^ cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    idx_next   = idx_reg;
    key_ready  = 1'b0;
    rk_valid   = 1'b0;
    case (state_reg)
      IDLE: begin
        key_ready = 1'b1;
        if (bus.key_valid) begin
          key_next   = bus.key_in;
          idx_next   = 5'd0;
          state_next = RUN;
        end
      end
      RUN: begin
        rk_valid = 1'b1;
        // The register only moves on an accepted key, so a stall holds rk_out.
        if (bus.rk_ready) begin
          if (idx_reg == 5'd31) begin
            state_next = IDLE;
          end else begin
            key_next = upd;
            idx_next = cnt;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.key_ready = key_ready;
  assign bus.rk_valid  = rk_valid;
  assign bus.rk_out    = key_reg[KEY_W-1 -: 64];
  assign bus.rk_idx    = idx_reg;
  assign bus.rk_last   = rk_valid & (idx_reg == 5'd31);
endmodule

// File: tb/tb_present_key_sched_seq.sv
// Drives the 80-bit and 128-bit schedulers in lockstep and checks them against
// a from-scratch round-key model plus a few hand-computed values.
module tb_present_key_sched_seq;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         rk_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  present_key_sched_seq_if #(.KEY_128(1'b0)) if80 ();
  present_key_sched_seq_if #(.KEY_128(1'b1)) if128 ();

  assign if80.key_in     = key_in[79:0];
  assign if80.key_valid  = key_valid;
  assign if80.rk_ready   = rk_ready;
  assign if128.key_in    = key_in;
  assign if128.key_valid = key_valid;
  assign if128.rk_ready  = rk_ready;

  present_key_sched_seq #(.KEY_128(1'b0)) dut80 (.clk(clk), .rst_n(rst_n), .bus(if80));
  present_key_sched_seq #(.KEY_128(1'b1)) dut128 (.clk(clk), .rst_n(rst_n), .bus(if128));

  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic logic [127:0] key_update(logic [127:0] k, int w, int c);
    logic [127:0] t;
    logic [4:0]   c5;
    int           pos;
    t = '0;
    for (int i = 0; i < w; i++) t[(i + 61) % w] = k[i];
    t[w-1 -: 4] = SB[t[w-1 -: 4]];
    if (w == 128) t[123:120] = SB[t[123:120]];
    pos = (w == 128) ? 62 : 15;
    c5 = c[4:0];
    t[pos +: 5] = t[pos +: 5] ^ c5;
    return t;
  endfunction

  function automatic logic [63:0] round_key(logic [127:0] master, int w, int i);
    logic [127:0] k;
    k = (w == 128) ? master : {48'd0, master[79:0]};
    for (int r = 1; r <= i; r++) k = key_update(k, w, r);
    return k[w-1 -: 64];
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference sequencer: idle/busy plus current round position.
  logic         busy;
  int           pos;
  logic [127:0] mk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      pos  <= 0;
      mk   <= '0;
    end else if (!busy) begin
      if (key_valid) begin
        mk   <= key_in;
        busy <= 1'b1;
        pos  <= 0;
      end
    end else if (rk_ready) begin
      if (pos == 31) busy <= 1'b0;
      else pos <= pos + 1;
    end
  end

  logic        stall_prev = 1'b0;
  logic [63:0] out80_prev, out128_prev;
  logic [4:0]  idx80_prev, idx128_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      check("key_ready80", 64'(if80.key_ready), 64'(!busy));
      check("key_ready128", 64'(if128.key_ready), 64'(!busy));
      check("rk_valid80", 64'(if80.rk_valid), 64'(busy));
      check("rk_valid128", 64'(if128.rk_valid), 64'(busy));
      check("rk_last80", 64'(if80.rk_last), 64'(busy && pos == 31));
      check("rk_last128", 64'(if128.rk_last), 64'(busy && pos == 31));
      if (busy) begin
        check("rk_idx80", 64'(if80.rk_idx), 64'(pos));
        check("rk_idx128", 64'(if128.rk_idx), 64'(pos));
        check("rk_out80", if80.rk_out, round_key(mk, 80, pos));
        check("rk_out128", if128.rk_out, round_key(mk, 128, pos));
      end
      if (stall_prev) begin
        check("stall_out80", if80.rk_out, out80_prev);
        check("stall_out128", if128.rk_out, out128_prev);
        check("stall_idx80", 64'(if80.rk_idx), 64'(idx80_prev));
        check("stall_idx128", 64'(if128.rk_idx), 64'(idx128_prev));
      end
      stall_prev  = if80.rk_valid && !rk_ready;
      out80_prev  = if80.rk_out;
      out128_prev = if128.rk_out;
      idx80_prev  = if80.rk_idx;
      idx128_prev = if128.rk_idx;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  task automatic run_to_idle(input bit random_ready);
    int budget;
    budget = 300;
    while (busy && budget > 0) begin
      rk_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      budget--;
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL run_bound: sequence still busy after cycle budget");
    end
  endtask

  initial begin
    logic [127:0] rk;
    int budget;

    #2;
    check("rst_key_ready", 64'(if80.key_ready), 64'd1);
    check("rst_rk_valid", 64'(if128.rk_valid), 64'd0);
    check("rst_rk_out", if80.rk_out, 64'd0);
    check("rst_rk_idx", 64'(if128.rk_idx), 64'd0);
    check("rst_rk_last", 64'(if80.rk_last), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // All-zero key, rk_ready high: first three keys and the tail of the run.
    rk_ready = 1'b1;
    load_key('0);
    check("zero_k1_80", if80.rk_out, 64'h0000000000000000);
    check("zero_idx0", 64'(if80.rk_idx), 64'd0);
    step();
    check("zero_k2_80", if80.rk_out, 64'hC000000000000000);
    check("zero_k2_128", if128.rk_out, 64'hCC00000000000000);
    check("zero_idx1", 64'(if80.rk_idx), 64'd1);
    step();
    check("zero_k3_80", if80.rk_out, 64'h5000180000000001);
    check("zero_idx2", 64'(if80.rk_idx), 64'd2);
    for (int i = 0; i < 29; i++) step();
    check("zero_last", 64'(if80.rk_last), 64'd1);
    step();
    check("zero_ready_back", 64'(if80.key_ready), 64'd1);

    // All-ones key, full run.
    load_key({128{1'b1}});
    check("ones_k1_80", if80.rk_out, 64'hFFFFFFFFFFFFFFFF);
    run_to_idle(1'b0);

    // Random keys with a randomly stalling consumer.
    for (int n = 0; n < 4; n++) begin
      load_key({$urandom, $urandom, $urandom, $urandom});
      run_to_idle(1'b1);
    end

    // key_valid held high with a changing key: only taken while idle.
    key_valid = 1'b1;
    for (int i = 0; i < 90; i++) begin
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      rk_ready = (i % 3) != 0;
      step();
    end
    key_valid = 1'b0;
    run_to_idle(1'b0);

    // Reset pulsed part-way through a sequence.
    rk_ready = 1'b1;
    load_key(128'h0123456789ABCDEF_FEDCBA9876543210);
    budget = 50;
    while (pos != 10 && budget > 0) begin
      step();
      budget--;
    end
    check("reach_idx10", 64'(if80.rk_idx), 64'd10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid80", 64'(if80.rk_valid), 64'd0);
    check("mid_rst_valid128", 64'(if128.rk_valid), 64'd0);
    check("mid_rst_ready80", 64'(if80.key_ready), 64'd1);
    check("mid_rst_ready128", 64'(if128.key_ready), 64'd1);
    step();
    step();
    rst_n = 1'b1;
    step();
    rk = 128'h00000000000000AA_BBCCDDEEFF001122;
    load_key(rk);
    check("restart_idx", 64'(if80.rk_idx), 64'd0);
    check("restart_k1_80", if80.rk_out, rk[79:16]);
    check("restart_k1_128", if128.rk_out, rk[127:64]);
    run_to_idle(1'b1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
